gate_truth_table_sequencer: RTL and testbench
=============================================

// Module: gate_truth_table_sequencer
// PURPOSE
//  Upstream stimulus and downstream checker for the 2-input logic-gate block (NOT/AND/OR/NOR/XOR).
//  - Drives A/B through all four input vectors, 00 -> 01 -> 10 -> 11.
//  - Waits a settle time, then samples the five gate outputs and compares them to a golden model.
//  - Accumulates an error count and a per-gate failure mask; reports pass/fail when the sweep ends.
//  - Provides on-board self-test of the gate lab stage.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles A/B are held before the gate outputs are sampled (legal range >= 1)
//  ERR_W          3  width of errCount; the counter saturates at 2**ERR_W-1
// PORTS
//  Clocking: one clock, clk. Reset is rst, asynchronous and active-high.
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous active-high reset
//  start       in   1      level-sampled; starts a sweep when sampled high in IDLE or DONE
//  notIn       in   1      gate-block NOT output
//  andIn       in   1      gate-block AND output
//  orIn        in   1      gate-block OR output
//  norIn       in   1      gate-block NOR output
//  xorIn       in   1      gate-block XOR output
//  A           out  1      stimulus to gate block; registered
//  B           out  1      stimulus to gate block; registered
//  busy        out  1      high while in SETTLE or CHECK
//  done        out  1      high in DONE
//  pass        out  1      done && errCount==0
//  errCount    out  ERR_W  number of vectors with at least one mismatching gate; saturating
//  failMask    out  5      sticky per-gate failure flags: [0]NOT [1]AND [2]OR [3]NOR [4]XOR
//  vecIdx      out  2      index of the vector currently applied
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE; A, B, busy, done, pass, errCount, failMask, vecIdx all 0.
//  FSM states: IDLE, SETTLE, CHECK, DONE.
//  - IDLE: start=1 at an edge -> clear errCount and failMask; vecIdx=0; {A,B}=2'b00;
//    load settle counter with SETTLE_CYCLES-1; go to SETTLE.
//  - SETTLE: count down. At counter==0 go to CHECK. A and B are held stable throughout.
//  - CHECK (exactly 1 cycle): compare the inputs against the golden model computed from the registered A,B:
//    ~A, A&B, A|B, ~(A|B), A^B.
//    - Each mismatching gate ORs its bit into failMask.
//    - If any gate mismatches, errCount += 1, saturating at 2**ERR_W-1.
//    - If vecIdx==3, go to DONE.
//    - Otherwise vecIdx += 1, {A,B} = new vecIdx, reload the settle counter, go to SETTLE.
//  - DONE: results held; A and B keep 2'b11. start=1 -> restart exactly as from IDLE (counters cleared).
//  Timing:
//  - Each vector takes SETTLE_CYCLES+1 cycles.
//  - done rises 4*(SETTLE_CYCLES+1) cycles after the edge that sampled start; this is 12 cycles at the default.
//  - Done and the final results appear at the same edge.
//  Boundary conditions:
//  - start while busy: ignored.
//  - start held high continuously: restarts each time DONE is reached; DONE lasts 1 cycle.
//  - rst mid-sweep: immediate return to reset values; no partial results are kept.
//  - errCount maximum is 4, so saturation matters only for ERR_W < 3.
//  - Gate inputs are sampled only in CHECK; glitches during SETTLE are ignored.
// STRUCTURE
//  Package gate_tt_pkg:
//  - state enum {IDLE, SETTLE, CHECK, DONE};
//  - failMask bit indices (GATE_NOT=0 .. GATE_XOR=4);
//  - NUM_VECTORS=4.
//  Sub-module gate_golden_model: combinational; {A,B} -> expected 5-bit vector in failMask bit order.
//  Top: FSM, settle counter, vecIdx counter, compare/accumulate logic.
// TESTING
//  1. Correct gate block, SETTLE=2, start pulse:
//     done at +12 cycles; pass=1, errCount=0, failMask=0; A,B sequence 00,01,10,11.
//  2. XOR stuck at 0:
//     errCount=2 (vectors 01 and 10), failMask=5'b10000, pass=0.
//  3. All five outputs inverted:
//     errCount=4, failMask=5'b11111. With ERR_W=2, errCount saturates at 3.
//  4. rst asserted in CHECK of vector 2:
//     all outputs 0 asynchronously, state IDLE. A new start then completes a clean sweep, pass=1.
//  5. start pulsed while busy:
//     ignored; completion time unchanged. start in DONE clears errCount and failMask, then re-sweeps.
//  6. AND output glitching only during SETTLE, correct in CHECK:
//     pass=1.

Source files
------------

// File: rtl/gate_truth_table_sequencer_pkg.sv
// rtl/gate_truth_table_sequencer_pkg.sv - shared types and constants for the gate truth-table sequencer
// Purpose: FSM state encoding, failMask bit positions and sweep length.
// Ports:   none (package).
package gate_tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } seqState_t;

    // Bit positions inside failMask and inside the golden/observed gate vectors.
    localparam int GATE_NOT = 0;
    localparam int GATE_AND = 1;
    localparam int GATE_OR  = 2;
    localparam int GATE_NOR = 3;
    localparam int GATE_XOR = 4;

    localparam int NUM_GATES   = 5;
    localparam int NUM_VECTORS = 4;

endpackage

// File: rtl/gate_truth_table_sequencer_if.sv
// rtl/gate_truth_table_sequencer_if.sv - stimulus/response bundle between sequencer and gate block
// Purpose: groups start, the five gate outputs, the A/B stimulus and the result signals.
// Ports:   master = sequencer (drives A, B and results); slave = gate block / host side.
interface gate_truth_table_sequencer_if #(
    parameter int ERR_W = 3
);
    import gate_tt_pkg::*;

    logic                 start;
    logic                 notIn;
    logic                 andIn;
    logic                 orIn;
    logic                 norIn;
    logic                 xorIn;
    logic                 A;
    logic                 B;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     errCount;
    logic [NUM_GATES-1:0] failMask;
    logic [1:0]           vecIdx;

    modport master (
        input  start, notIn, andIn, orIn, norIn, xorIn,
        output A, B, busy, done, pass, errCount, failMask, vecIdx
    );

    modport slave (
        output start, notIn, andIn, orIn, norIn, xorIn,
        input  A, B, busy, done, pass, errCount, failMask, vecIdx
    );

endinterface

// File: rtl/gate_truth_table_sequencer_golden_model.sv
// rtl/gate_truth_table_sequencer_golden_model.sv - reference NOT/AND/OR/NOR/XOR for one input vector
// Purpose: combinational golden model, output ordered like failMask.
// Ports:   a, b in; expected[4:0] out ([0]NOT [1]AND [2]OR [3]NOR [4]XOR).
module gate_golden_model
    import gate_tt_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);

    always_comb begin
        expected           = '0;
        expected[GATE_NOT] = ~a;
        expected[GATE_AND] = a & b;
        expected[GATE_OR]  = a | b;
        expected[GATE_NOR] = ~(a | b);
        expected[GATE_XOR] = a ^ b;
    end

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// rtl/gate_truth_table_sequencer.sv - sweeps A/B over 00..11 and checks the gate block outputs
// Purpose: FSM IDLE->SETTLE->CHECK (x4)->DONE with settle counter, error counter and sticky fail mask.
// Ports:   clk, rst (async, active-high); bus (master): start and gate outputs in,
//          A, B, busy, done, pass, errCount, failMask, vecIdx out.
module gate_truth_table_sequencer
    import gate_tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    gate_truth_table_sequencer_if.master  bus
);

    localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [1:0]       LAST_VEC    = 2'(NUM_VECTORS - 1);

    seqState_t            state, stateNext;
    logic [CNT_W-1:0]     settleCnt, settleCntNext;
    logic [1:0]           vecIdx, vecIdxNext;
    logic                 aReg, aNext, bReg, bNext;
    logic [ERR_W-1:0]     errCount, errCountNext;
    logic [NUM_GATES-1:0] failMask, failMaskNext;
    logic [NUM_GATES-1:0] expected, observed, mismatch;

    // Golden values come from the registered stimulus, not from vecIdx, so a
    // stuck A/B register shows up as gate failures.
    gate_golden_model golden (
        .a        (aReg),
        .b        (bReg),
        .expected (expected)
    );

    always_comb begin
        observed           = '0;
        observed[GATE_NOT] = bus.notIn;
        observed[GATE_AND] = bus.andIn;
        observed[GATE_OR]  = bus.orIn;
        observed[GATE_NOR] = bus.norIn;
        observed[GATE_XOR] = bus.xorIn;
        mismatch           = observed ^ expected;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            settleCnt <= '0;
            vecIdx    <= '0;
            aReg      <= 1'b0;
            bReg      <= 1'b0;
            errCount  <= '0;
            failMask  <= '0;
        end else begin
            state     <= stateNext;
            settleCnt <= settleCntNext;
            vecIdx    <= vecIdxNext;
            aReg      <= aNext;
            bReg      <= bNext;
            errCount  <= errCountNext;
            failMask  <= failMaskNext;
        end
    end

    always_comb begin
        stateNext     = state;
        settleCntNext = settleCnt;
        vecIdxNext    = vecIdx;
        aNext         = aReg;
        bNext         = bReg;
        errCountNext  = errCount;
        failMaskNext  = failMask;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    errCountNext  = '0;
                    failMaskNext  = '0;
                    vecIdxNext    = '0;
                    aNext         = 1'b0;
                    bNext         = 1'b0;
                    settleCntNext = SETTLE_LOAD;
                    stateNext     = SETTLE;
                end
            end
            SETTLE: begin
                if (settleCnt == '0) begin
                    stateNext = CHECK;
                end else begin
                    settleCntNext = settleCnt - 1'b1;
                end
            end
            CHECK: begin
                failMaskNext = failMask | mismatch;
                if ((|mismatch) && (errCount != ERR_MAX)) begin
                    errCountNext = errCount + 1'b1;
                end
                if (vecIdx == LAST_VEC) begin
                    stateNext = DONE;
                end else begin
                    vecIdxNext       = vecIdx + 1'b1;
                    {aNext, bNext}   = vecIdx + 1'b1;
                    settleCntNext    = SETTLE_LOAD;
                    stateNext        = SETTLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.A        = aReg;
    assign bus.B        = bReg;
    assign bus.busy     = (state == SETTLE) || (state == CHECK);
    assign bus.done     = (state == DONE);
    assign bus.pass     = (state == DONE) && (errCount == '0);
    assign bus.errCount = errCount;
    assign bus.failMask = failMask;
    assign bus.vecIdx   = vecIdx;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// tb/tb_gate_truth_table_sequencer.sv - directed bench for gate_truth_table_sequencer (ERR_W=3 and ERR_W=2)
module tb_gate_truth_table_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic glitchAnd;
    int   faultMode;   // 0 correct, 1 XOR stuck at 0, 2 all outputs inverted
    int   nCompared = 0;
    int   nMismatch = 0;

    always #5 clk = ~clk;

    gate_truth_table_sequencer_if #(.ERR_W(3)) bus3 ();
    gate_truth_table_sequencer_if #(.ERR_W(2)) bus2 ();

    gate_truth_table_sequencer #(.SETTLE_CYCLES(2), .ERR_W(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    gate_truth_table_sequencer #(.SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Behavioural gate block with fault injection; order [0]NOT [1]AND [2]OR [3]NOR [4]XOR.
    function automatic logic [4:0] gateBlock(input logic a, input logic b, input int mode, input logic glitch);
        logic [4:0] g;
        g[0] = ~a;
        g[1] = a & b;
        g[2] = a | b;
        g[3] = ~(a | b);
        g[4] = a ^ b;
        if (mode == 2) g = ~g;
        if (mode == 1) g[4] = 1'b0;
        g[1] = g[1] ^ glitch;
        return g;
    endfunction

    logic [4:0] g3, g2;
    assign g3 = gateBlock(bus3.A, bus3.B, faultMode, glitchAnd);
    assign g2 = gateBlock(bus2.A, bus2.B, faultMode, glitchAnd);

    assign bus3.start = start;
    assign bus3.notIn = g3[0];
    assign bus3.andIn = g3[1];
    assign bus3.orIn  = g3[2];
    assign bus3.norIn = g3[3];
    assign bus3.xorIn = g3[4];
    assign bus2.start = start;
    assign bus2.notIn = g2[0];
    assign bus2.andIn = g2[1];
    assign bus2.orIn  = g2[2];
    assign bus2.norIn = g2[3];
    assign bus2.xorIn = g2[4];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkEq({tag, "/idle3"},
                {bus3.A, bus3.B, bus3.busy, bus3.done, bus3.pass, bus3.errCount, bus3.failMask, bus3.vecIdx}, 0);
        checkEq({tag, "/idle2"},
                {bus2.A, bus2.B, bus2.busy, bus2.done, bus2.pass, bus2.errCount, bus2.failMask, bus2.vecIdx}, 0);
    endtask

    // Pulse start, run the 12 sweep edges, then check the final results.
    task automatic sweep(input string tag, input int pulseAt, input bit glitch,
                         input logic [2:0] expErr3, input logic [1:0] expErr2, input logic [4:0] expMask);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkEq({tag, "/startBusy"}, {bus3.busy, bus3.done}, 2'b10);
        checkEq({tag, "/cleared"}, {bus3.errCount, bus3.failMask, bus2.errCount, bus2.failMask}, 0);
        for (int c = 1; c <= 12; c++) begin
            glitchAnd = glitch && ((c % 3) != 0);   // edges 3,6,9,12 end a CHECK cycle
            start     = (c == pulseAt);
            @(posedge clk);
            @(negedge clk);
            if ((c % 3) == 1)
                checkEq($sformatf("%s/ab%0d", tag, c / 3), {bus3.A, bus3.B}, c / 3);
            if (c == 11)
                checkEq({tag, "/preDone"}, {bus3.busy, bus3.done}, 2'b10);
        end
        glitchAnd = 1'b0;
        start     = 1'b0;
        checkEq({tag, "/done3"}, {bus3.done, bus3.busy, bus3.pass}, {2'b10, expErr3 == 3'd0});
        checkEq({tag, "/done2"}, {bus2.done, bus2.busy, bus2.pass}, {2'b10, expErr3 == 3'd0});
        checkEq({tag, "/err3"}, bus3.errCount, expErr3);
        checkEq({tag, "/err2"}, bus2.errCount, expErr2);
        checkEq({tag, "/mask3"}, bus3.failMask, expMask);
        checkEq({tag, "/mask2"}, bus2.failMask, expMask);
        checkEq({tag, "/vec"}, bus3.vecIdx, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        glitchAnd = 1'b0;
        faultMode = 0;
        @(negedge clk);
        checkIdle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("idleNoStart");

        faultMode = 0;
        sweep("clean", -1, 1'b0, 3'd0, 2'd0, 5'b00000);

        faultMode = 1;
        sweep("xorStuck", -1, 1'b0, 3'd2, 2'd2, 5'b10000);

        faultMode = 0;
        sweep("restartInDone", -1, 1'b0, 3'd0, 2'd0, 5'b00000);

        faultMode = 2;
        sweep("inverted", -1, 1'b0, 3'd4, 2'd3, 5'b11111);

        faultMode = 0;
        sweep("busyStart", 5, 1'b0, 3'd0, 2'd0, 5'b00000);

        sweep("andGlitch", -1, 1'b1, 3'd0, 2'd0, 5'b00000);

        // start held high: DONE lasts one cycle, then the sweep restarts.
        @(negedge clk);
        start = 1'b1;
        repeat (13) @(posedge clk);
        @(negedge clk);
        checkEq("hold/done", {bus3.done, bus3.pass}, 2'b11);
        @(posedge clk);
        @(negedge clk);
        checkEq("hold/restart", {bus3.busy, bus3.done}, 2'b10);
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkEq("hold/done2", {bus3.done, bus3.pass}, 2'b11);

        // Reset during CHECK of vector 2, with one error already accumulated.
        faultMode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkEq("midRst/pre", {bus3.busy, bus3.vecIdx, bus3.errCount}, {1'b1, 2'd2, 3'd1});
        rst = 1'b1;
        #1;
        checkIdle("midRst/async");
        @(negedge clk);
        rst       = 1'b0;
        faultMode = 0;
        @(negedge clk);
        checkIdle("midRst/stay");
        sweep("afterRst", -1, 1'b0, 3'd0, 2'd0, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
